stage3_fetch_ctrl: RTL

STAGE3_FETCH_CTRL -- requirements
Module: stage3_fetch_ctrl

---
 rtl/stage3_fetch_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/stage3_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// stage3_fetch_ctrl
//
// Purpose:
//   Instruction-fetch controller for a 3-stage pipeline. It owns the fetch
//   PC (pc_f), issues single-word reads on the instruction bus, and fills
//   the IF/EX pipeline latch. Redirects (trap vector, rollback, branch)
//   are honored in the cycle they are raised. If a redirect arrives while a
//   bus read is still outstanding, the controller moves to DRAIN. In DRAIN
//   it waits for that read to finish, discards the word, and then jumps to
//   the pending target. A 1-entry skid buffer holds a word that completes
//   while the IF/EX latch is stalled.
//
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   pc_en                        advance PC to pc_f+4 on completion
//   npc_sel / br_target          branch/jump redirect (lowest priority)
//   insert_priv_pc / priv_pc     trap-vector redirect (highest priority)
//   rollback / rollback_pc       refetch redirect (middle priority)
//   if_ex_stall, if_ex_flush     IF/EX latch hold / invalidate
//   iren, suppress_iren          fetch enable / fetch suppression
//   ibus_ren, ibus_addr          instruction bus request
//   ibus_busy, ibus_rdata        instruction bus response
//   i_mem_busy                   fetch-side busy indication to hazard unit
//   pc_f                         current fetch PC
//   inst_e, pc_e, valid_e,
//   mal_insn_e                   IF/EX latch contents
//   dbg_state                    FSM state (0 = RUN, 1 = DRAIN)
//
// Handshake: a bus read is outstanding while ibus_ren=1. The read completes
// in any cycle where ibus_ren=1 and ibus_busy=0, and ibus_rdata is valid in
// that cycle only. ibus_addr stays stable while ibus_busy=1.
// ---------------------------------------------------------------------------
module stage3_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        pc_en,
   input  logic        npc_sel,
   input  logic [31:0] br_target,
   input  logic        insert_priv_pc,
   input  logic [31:0] priv_pc,
   input  logic        rollback,
   input  logic [31:0] rollback_pc,
   input  logic        if_ex_stall,
   input  logic        if_ex_flush,
   input  logic        iren,
   input  logic        suppress_iren,
   output logic        ibus_ren,
   output logic [31:0] ibus_addr,
   input  logic        ibus_busy,
   input  logic [31:0] ibus_rdata,
   output logic        i_mem_busy,
   output logic [31:0] pc_f,
   output logic [31:0] inst_e,
   output logic [31:0] pc_e,
   output logic        valid_e,
   output logic        mal_insn_e,
   output logic        dbg_state
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pending_pc_q, pending_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_data_q, skid_data_d;
   logic        valid_e_q, valid_e_d;
   logic        mal_e_q, mal_e_d;
   logic [31:0] inst_e_q, inst_e_d;
   logic [31:0] pc_e_q, pc_e_d;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic        aligned;
   logic        in_run;
   logic        ren;
   logic        cap;
   logic        cap_mal;
   logic [31:0] cap_inst;

   assign redirect    = insert_priv_pc | rollback | npc_sel;
   assign redirect_pc = insert_priv_pc ? priv_pc :
                        rollback       ? rollback_pc : br_target;
   assign aligned     = (pc_q[1:0] == 2'b00);
   assign in_run      = (state_q == ST_RUN);

   // A buffered word stands in for a new request, so none is issued while
   // the skid buffer is occupied. DRAIN keeps the old read alive until the
   // bus lets it go. nRST gates the outputs so they read low during reset.
   assign ren = nRST & ((in_run & iren & ~suppress_iren & aligned & ~skid_valid_q)
                        | ~in_run);

   assign ibus_ren   = ren;
   assign ibus_addr  = {pc_q[31:2], 2'b00};
   assign i_mem_busy = nRST & ((ren & ibus_busy) | ~in_run | (iren & suppress_iren));
   assign pc_f       = pc_q;
   assign inst_e     = inst_e_q;
   assign pc_e       = pc_e_q;
   assign valid_e    = valid_e_q;
   assign mal_insn_e = mal_e_q;
   assign dbg_state  = state_q;

   // Next-state, PC and skid-buffer logic.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      cap          = 1'b0;
      cap_mal      = 1'b0;
      cap_inst     = ibus_rdata;

      case (state_q)
         ST_RUN: begin
            if (redirect) begin
               skid_valid_d = 1'b0;
               if (ren && ibus_busy) begin
                  // The read in flight cannot be cancelled. Park the target
                  // and let the read finish on the old address.
                  state_d      = ST_DRAIN;
                  pending_pc_d = redirect_pc;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (skid_valid_q) begin
               if (!if_ex_stall) begin
                  skid_valid_d = 1'b0;
                  cap          = ~if_ex_flush;
                  cap_inst     = skid_data_q;
                  if (pc_en) pc_d = pc_q + 32'd4;
               end
            end else if (ren && !ibus_busy) begin
               // Completion of a fetch.
               if (if_ex_stall && !if_ex_flush) begin
                  skid_valid_d = 1'b1;
                  skid_data_d  = ibus_rdata;
               end else begin
                  cap = ~if_ex_flush;
                  if (pc_en) pc_d = pc_q + 32'd4;
               end
            end else if (!aligned && iren && !suppress_iren) begin
               // Misaligned PC: hand a flagged NOP downstream. The PC stays
               // put until a redirect moves it.
               cap      = ~if_ex_stall & ~if_ex_flush;
               cap_mal  = 1'b1;
               cap_inst = NOP;
            end
         end

         ST_DRAIN: begin
            if (redirect) pending_pc_d = redirect_pc;
            if (!ibus_busy) begin
               // The word completing here belongs to the abandoned path.
               state_d = ST_RUN;
               pc_d    = redirect ? redirect_pc : pending_pc_q;
            end
         end

         default: state_d = ST_RUN;
      endcase
   end

   // IF/EX latch next-state: flush wins, then capture, then stall/hold.
   always_comb begin
      valid_e_d = valid_e_q;
      mal_e_d   = mal_e_q;
      inst_e_d  = inst_e_q;
      pc_e_d    = pc_e_q;
      if (if_ex_flush) begin
         valid_e_d = 1'b0;
         mal_e_d   = 1'b0;
      end else if (cap) begin
         valid_e_d = 1'b1;
         mal_e_d   = cap_mal;
         inst_e_d  = cap_inst;
         pc_e_d    = pc_q;
      end else if (!if_ex_stall) begin
         valid_e_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         pending_pc_q <= 32'h0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= 32'h0;
         valid_e_q    <= 1'b0;
         mal_e_q      <= 1'b0;
         inst_e_q     <= 32'h0;
         pc_e_q       <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         valid_e_q    <= valid_e_d;
         mal_e_q      <= mal_e_d;
         inst_e_q     <= inst_e_d;
         pc_e_q       <= pc_e_d;
      end
   end

endmodule
